// File: rtl/core_pkg.sv
// Shared EX-stage definitions: ALU control codes, MDU op encodings and
// the multiply/divide sequencer state type.
package core_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] MD_MUL  = 2'b00;
   localparam logic [1:0] MD_DIVU = 2'b01;
   localparam logic [1:0] MD_REMU = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MUL_STEP = 3'd1,
      ST_DIV_CMP  = 3'd2,
      ST_DIV_SUB  = 3'd3,
      ST_DONE     = 3'd4
   } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer that borrows the shared EX-stage ALU,
// issuing one ALU operation per cycle; only shifts and bit tests are local.
module muldiv_seq
   import core_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             alu_req,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);

   md_state_e        state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, or divisor for DIVU/REMU
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] rem_s_q, rem_s_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             lt_flag_q, lt_flag_d;
   logic             msb_q, msb_d;
   logic [WIDTH-1:0] rem_shift;
   logic             take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         rem_s_q   <= '0;
         quo_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         lt_flag_q <= 1'b0;
         msb_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         rem_q     <= rem_d;
         rem_s_q   <= rem_s_d;
         quo_q     <= quo_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         lt_flag_q <= lt_flag_d;
         msb_q     <= msb_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rem_d     = rem_q;
      rem_s_d   = rem_s_q;
      quo_d     = quo_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      lt_flag_d = lt_flag_q;
      msb_d     = msb_q;
      alu_req   = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_ctrl  = ALU_AND;
      rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      // A bit shifted out of rem means the shifted value already exceeds the divisor.
      take      = msb_q | ~lt_flag_q;

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cnt_d = '0;
                  op_d  = op;
                  if (op == MD_DIVU || op == MD_REMU) begin
                     if (opb == '0) begin
                        result_d = (op == MD_REMU) ? opa : '1;
                        state_d  = ST_DONE;
                     end else begin
                        rem_d   = '0;
                        quo_d   = opa;
                        mcand_d = opb;
                        state_d = ST_DIV_CMP;
                     end
                  end else begin
                     acc_d    = '0;
                     mcand_d  = opa;
                     mplier_d = opb;
                     state_d  = ST_MUL_STEP;
                  end
               end
            end
            ST_MUL_STEP: begin
               alu_req  = 1'b1;
               alu_a    = acc_q;
               alu_b    = mcand_q;
               alu_ctrl = ALU_ADD;
               if (mplier_q[0]) acc_d = alu_result;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_d = acc_d;
                  state_d  = ST_DONE;
               end
            end
            ST_DIV_CMP: begin
               alu_req   = 1'b1;
               alu_a     = rem_shift;
               alu_b     = mcand_q;
               alu_ctrl  = ALU_SLT;
               lt_flag_d = alu_result[0];
               rem_s_d   = rem_shift;
               msb_d     = rem_q[WIDTH-1];
               state_d   = ST_DIV_SUB;
            end
            ST_DIV_SUB: begin
               alu_req  = 1'b1;
               alu_a    = rem_s_q;
               alu_b    = mcand_q;
               alu_ctrl = ALU_SUB;
               rem_d    = take ? alu_result : rem_s_q;
               quo_d    = {quo_q[WIDTH-2:0], take};
               cnt_d    = cnt_q + 1'b1;
               if (cnt_d == CNT_END) begin
                  result_d = (op_q == MD_REMU) ? rem_d : quo_d;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_DIV_CMP;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural model of the shared ALU
// and hand-computed results, latencies and ALU control sequences.
module tb_muldiv_seq;
   import core_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] opa, opb;
   logic         flush;
   logic         busy, done, alu_req;
   logic [W-1:0] result, alu_a, alu_b, alu_result;
   logic [3:0]   alu_ctrl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op         (op),
      .opa        (opa),
      .opb        (opb),
      .flush      (flush),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .alu_req    (alu_req),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result)
   );

   // Shared EX-stage ALU; SLT is the unsigned compare used by the divider.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_AND: alu_result = alu_a & alu_b;
         ALU_OR:  alu_result = alu_a | alu_b;
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_SLT: alu_result = {{(W-1){1'b0}}, (alu_a < alu_b)};
         ALU_NOR: alu_result = ~(alu_a | alu_b);
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one op in the current cycle (cycle 0) and follows it to done.
   // ctrl_odd/ctrl_even: expected alu_ctrl in odd/even cycles while alu_req=1.
   // pulse_at: cycle in which a competing start is re-pulsed (0 = none).
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_lat,
                         input logic [3:0] ctrl_odd, input logic [3:0] ctrl_even,
                         input int pulse_at);
      int cyc;
      int ctrl_err;
      cyc      = 0;
      ctrl_err = 0;
      start = 1'b1; op = o; opa = a; opb = b;
      do begin
         step();
         cyc++;
         start = 1'b0;
         opa   = $urandom;
         opb   = $urandom;
         if (cyc == pulse_at) begin
            start = 1'b1;
            op    = MD_MUL;
         end
         if (alu_req && alu_ctrl !== ((cyc % 2 == 1) ? ctrl_odd : ctrl_even)) ctrl_err++;
         if (done && (alu_req || !busy)) ctrl_err++;
      end while (!done && cyc < 200);
      start = 1'b0;
      check({tag, "_latency"}, W'(cyc), W'(exp_lat));
      check({tag, "_result"}, result, exp_res);
      check({tag, "_alu_seq"}, W'(ctrl_err), '0);
      step();
      check({tag, "_idle_after"}, {30'b0, busy, done}, '0);
   endtask

   initial begin
      int cyc;
      int saw_done;
      rst_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0; flush = 1'b0;
      repeat (3) step();
      check("reset_outs", {28'b0, busy, done, alu_req, 1'b0}, '0);
      check("reset_result", result, '0);
      check("reset_alu", alu_a | alu_b | {28'b0, alu_ctrl}, '0);
      rst_n = 1'b1;
      step();

      run_op("mul_7x6", MD_MUL, 32'd7, 32'd6, 32'd42, 33, ALU_ADD, ALU_ADD, 0);
      run_op("mul_ffff", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33, ALU_ADD, ALU_ADD, 0);
      run_op("mul_ovf", MD_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 33, ALU_ADD, ALU_ADD, 0);
      run_op("mul_op11", 2'b11, 32'd4, 32'd4, 32'd16, 33, ALU_ADD, ALU_ADD, 0);
      run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd14, 65, ALU_SLT, ALU_SUB, 0);
      run_op("remu_100_7", MD_REMU, 32'd100, 32'd7, 32'd2, 65, ALU_SLT, ALU_SUB, 0);
      run_op("divu_max_1", MD_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 65, ALU_SLT, ALU_SUB, 0);
      run_op("remu_msb", MD_REMU, 32'h8000_0001, 32'h8000_0000, 32'd1, 65, ALU_SLT, ALU_SUB, 0);
      run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, ALU_SLT, ALU_SUB, 0);
      run_op("remu_by0", MD_REMU, 32'd5, 32'd0, 32'd5, 1, ALU_SLT, ALU_SUB, 0);
      run_op("divu_restart", MD_DIVU, 32'd1000, 32'd10, 32'd100, 65, ALU_SLT, ALU_SUB, 5);

      // Flush mid-divide: idle the next cycle, no done, result keeps 100.
      start = 1'b1; op = MD_DIVU; opa = 32'd50; opb = 32'd3;
      cyc = 0; saw_done = 0;
      while (cyc < 10) begin
         step();
         cyc++;
         start = 1'b0;
         if (done) saw_done++;
      end
      check("flush_busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_idle", {30'b0, busy, alu_req}, '0);
      repeat (70) begin
         step();
         if (done || busy) saw_done++;
      end
      check("flush_no_done", W'(saw_done), '0);
      check("flush_result", result, 32'd100);

      // Flush and start together in IDLE: start is dropped.
      flush = 1'b1; start = 1'b1; op = MD_MUL; opa = 32'd2; opb = 32'd2;
      step();
      flush = 1'b0; start = 1'b0;
      check("flush_start_idle", {31'b0, busy}, '0);
      step();
      check("flush_start_result", result, 32'd100);

      // Asynchronous reset in cycle 20 of a multiply.
      start = 1'b1; op = MD_MUL; opa = 32'd9; opb = 32'd9;
      repeat (20) begin
         step();
         start = 1'b0;
      end
      check("mid_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {28'b0, busy, done, alu_req, 1'b0}, '0);
      check("rst_mid_result", result, '0);
      check("rst_mid_alu", alu_a | alu_b | {28'b0, alu_ctrl}, '0);
      step();
      rst_n = 1'b1;
      step();
      run_op("mul_3x5", MD_MUL, 32'd3, 32'd5, 32'd15, 33, ALU_ADD, ALU_ADD, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
